// File: rtl/tb_pkg.sv
// Shared definitions for the pattern transaction engine:
// FSM state encoding and the LFSR polynomial constants.
package tb_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_DRIVE = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_RECV  = 3'd3;
   localparam logic [2:0] ST_GAP   = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

   // Taps for x^16+x^14+x^13+x^11+1 on a left-shifting register
   localparam logic [15:0] LFSR_TAPS         = 16'hB400;
   localparam logic [15:0] LFSR_DEFAULT_SEED = 16'h0001;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/pattern_lfsr16.sv
// 16-bit Fibonacci LFSR with seed load; exposes the low FIELD_W state bits
// that feed the request fields.
module pattern_lfsr16
   import tb_pkg::*;
#(
   parameter int FIELD_W = 7
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic [15:0]        seed,
   input  logic               advance,
   output logic [FIELD_W-1:0] field_bits
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   // An all-zero seed would lock the register, so it is replaced by the default
   always_comb begin
      lfsr_d = lfsr_q;
      if (load) begin
         lfsr_d = (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
      end else if (advance) begin
         lfsr_d = lfsr_step(lfsr_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= LFSR_DEFAULT_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign field_bits = lfsr_q[FIELD_W-1:0];

endmodule

// File: rtl/pattern_txn_engine.sv
// Stimulus/response engine: issues LFSR-randomised requests, then measures
// response latency, accumulates a checksum and flags timeout/protocol errors.
module pattern_txn_engine
   import tb_pkg::*;
#(
   parameter int PIC_W   = 4,
   parameter int RATIO_W = 2,
   parameter int DATA_W  = 8,
   parameter int OUT_LEN = 1,
   parameter int MAX_LAT = 1000,
   parameter int GAP     = 2,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [CNT_W-1:0]   num_txn,
   input  logic [15:0]        seed,
   output logic               drv_valid,
   output logic [PIC_W-1:0]   drv_pic_no,
   output logic               drv_mode,
   output logic [RATIO_W-1:0] drv_ratio_mode,
   input  logic               dut_out_valid,
   input  logic [DATA_W-1:0]  dut_out_data,
   output logic               busy,
   output logic               done,
   output logic               err_timeout,
   output logic               err_protocol,
   output logic [CNT_W-1:0]   txn_cnt,
   output logic [CNT_W-1:0]   max_lat,
   output logic [DATA_W-1:0]  checksum
);

   localparam int FIELD_W = PIC_W + RATIO_W + 1;
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] OUT_LEN_C = CNT_W'(OUT_LEN);
   localparam logic [CNT_W-1:0] MAX_LAT_C = CNT_W'(MAX_LAT);
   localparam logic [CNT_W-1:0] GAP_C     = CNT_W'(GAP);

   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  num_q, num_d;
   logic [CNT_W-1:0]  lat_q, lat_d;
   logic [CNT_W-1:0]  beat_q, beat_d;
   logic [CNT_W-1:0]  gap_q, gap_d;
   logic [CNT_W-1:0]  txn_q, txn_d;
   logic [CNT_W-1:0]  max_lat_q, max_lat_d;
   logic [DATA_W-1:0] sum_q, sum_d;
   logic              err_to_q, err_to_d;
   logic              err_pr_q, err_pr_d;
   logic              lfsr_load;
   logic              lfsr_adv;
   logic              complete;
   logic [FIELD_W-1:0] field_bits;

   pattern_lfsr16 #(.FIELD_W(FIELD_W)) u_lfsr (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (lfsr_load),
      .seed       (seed),
      .advance    (lfsr_adv),
      .field_bits (field_bits)
   );

   always_comb begin
      state_d   = state_q;
      num_d     = num_q;
      lat_d     = lat_q;
      beat_d    = beat_q;
      gap_d     = gap_q;
      txn_d     = txn_q;
      max_lat_d = max_lat_q;
      sum_d     = sum_q;
      err_to_d  = err_to_q;
      err_pr_d  = err_pr_q;
      lfsr_load = 1'b0;
      lfsr_adv  = 1'b0;
      complete  = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               num_d     = num_txn;
               txn_d     = '0;
               max_lat_d = '0;
               sum_d     = '0;
               err_to_d  = 1'b0;
               err_pr_d  = 1'b0;
               lfsr_load = 1'b1;
               state_d   = (num_txn == '0) ? ST_DONE : ST_DRIVE;
            end else if (dut_out_valid) begin
               err_pr_d = 1'b1;
            end
         end
         ST_DRIVE: begin
            lfsr_adv = 1'b1;
            lat_d    = ONE;
            state_d  = ST_WAIT;
            if (dut_out_valid) err_pr_d = 1'b1;
         end
         ST_WAIT: begin
            if (dut_out_valid) begin
               if (lat_q > max_lat_q) max_lat_d = lat_q;
               sum_d  = sum_q + dut_out_data;
               beat_d = ONE;
               if (OUT_LEN_C == ONE) complete = 1'b1;
               else                  state_d  = ST_RECV;
            end else begin
               if (lat_q != '1) lat_d = lat_q + ONE;
               if (lat_d >= MAX_LAT_C) begin
                  err_to_d = 1'b1;
                  state_d  = ST_DONE;
               end
            end
         end
         ST_RECV: begin
            if (dut_out_valid) begin
               sum_d  = sum_q + dut_out_data;
               beat_d = beat_q + ONE;
               if (beat_d >= OUT_LEN_C) complete = 1'b1;
            end else begin
               err_pr_d = 1'b1;
               state_d  = ST_DONE;
            end
         end
         ST_GAP: begin
            if (dut_out_valid) err_pr_d = 1'b1;
            if (gap_q + ONE >= GAP_C) state_d = ST_DRIVE;
            else                      gap_d   = gap_q + ONE;
         end
         default: state_d = ST_IDLE;
      endcase

      // A finished response either ends the run or heads to the next request
      if (complete) begin
         if (txn_q < num_q) txn_d = txn_q + ONE;
         gap_d = '0;
         if (txn_d >= num_q)     state_d = ST_DONE;
         else if (GAP_C == '0)   state_d = ST_DRIVE;
         else                    state_d = ST_GAP;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         num_q     <= '0;
         lat_q     <= '0;
         beat_q    <= '0;
         gap_q     <= '0;
         txn_q     <= '0;
         max_lat_q <= '0;
         sum_q     <= '0;
         err_to_q  <= 1'b0;
         err_pr_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         num_q     <= num_d;
         lat_q     <= lat_d;
         beat_q    <= beat_d;
         gap_q     <= gap_d;
         txn_q     <= txn_d;
         max_lat_q <= max_lat_d;
         sum_q     <= sum_d;
         err_to_q  <= err_to_d;
         err_pr_q  <= err_pr_d;
      end
   end

   assign drv_valid      = (state_q == ST_DRIVE);
   assign drv_pic_no     = drv_valid ? field_bits[PIC_W-1:0] : '0;
   assign drv_mode       = drv_valid & field_bits[PIC_W];
   assign drv_ratio_mode = drv_valid ? field_bits[PIC_W+RATIO_W:PIC_W+1] : '0;
   assign busy           = (state_q == ST_DRIVE) || (state_q == ST_WAIT) ||
                           (state_q == ST_RECV)  || (state_q == ST_GAP);
   assign done           = (state_q == ST_DONE);
   assign err_timeout    = err_to_q;
   assign err_protocol   = err_pr_q;
   assign txn_cnt        = txn_q;
   assign max_lat        = max_lat_q;
   assign checksum       = sum_q;

endmodule

// File: tb/tb_pattern_txn_engine.sv
// Self-checking bench for pattern_txn_engine: directed and randomised runs
// compared against a transaction-level reference model.
module tb_pattern_txn_engine;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        start = 1'b0;
   logic [15:0] num_txn = '0;
   logic [15:0] seed = '0;
   logic        drv_valid;
   logic [3:0]  drv_pic_no;
   logic        drv_mode;
   logic [1:0]  drv_ratio_mode;
   logic        out_valid = 1'b0;
   logic [7:0]  out_data = '0;
   logic        busy, done, err_timeout, err_protocol;
   logic [15:0] txn_cnt, max_lat;
   logic [7:0]  checksum;

   logic        start4 = 1'b0;
   logic [15:0] num_txn4 = '0;
   logic [15:0] seed4 = '0;
   logic        drv_valid4;
   logic [3:0]  drv_pic_no4;
   logic        drv_mode4;
   logic [1:0]  drv_ratio_mode4;
   logic        out_valid4 = 1'b0;
   logic [7:0]  out_data4 = '0;
   logic        busy4, done4, err_timeout4, err_protocol4;
   logic [15:0] txn_cnt4, max_lat4;
   logic [7:0]  checksum4;

   int tests = 0;
   int fails = 0;

   logic [15:0] m_lfsr;
   logic [7:0]  m_sum;
   int          m_max;
   logic [6:0]  last_fields;

   always #5 clk = ~clk;

   pattern_txn_engine u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_txn(num_txn), .seed(seed),
      .drv_valid(drv_valid), .drv_pic_no(drv_pic_no), .drv_mode(drv_mode),
      .drv_ratio_mode(drv_ratio_mode), .dut_out_valid(out_valid),
      .dut_out_data(out_data), .busy(busy), .done(done),
      .err_timeout(err_timeout), .err_protocol(err_protocol),
      .txn_cnt(txn_cnt), .max_lat(max_lat), .checksum(checksum)
   );

   pattern_txn_engine #(.OUT_LEN(4), .MAX_LAT(50), .GAP(0)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .num_txn(num_txn4), .seed(seed4),
      .drv_valid(drv_valid4), .drv_pic_no(drv_pic_no4), .drv_mode(drv_mode4),
      .drv_ratio_mode(drv_ratio_mode4), .dut_out_valid(out_valid4),
      .dut_out_data(out_data4), .busy(busy4), .done(done4),
      .err_timeout(err_timeout4), .err_protocol(err_protocol4),
      .txn_cnt(txn_cnt4), .max_lat(max_lat4), .checksum(checksum4)
   );

   // Reference LFSR written straight from the polynomial x^16+x^14+x^13+x^11+1
   function automatic logic [15:0] model_next(input logic [15:0] s);
      int   taps [4];
      logic fb;
      taps = '{16, 14, 13, 11};
      fb = 1'b0;
      foreach (taps[i]) fb = fb ^ s[taps[i]-1];
      return {s[14:0], fb};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_run(input logic [15:0] n, input logic [15:0] sd);
      @(negedge clk);
      start   = 1'b1;
      num_txn = n;
      seed    = sd;
      m_lfsr  = (sd == 16'h0000) ? 16'h0001 : sd;
      m_sum   = '0;
      m_max   = 0;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_drv(input string tag);
      for (int i = 0; i < 200; i++) begin
         if (drv_valid) break;
         @(negedge clk);
      end
      check({tag, "_drv_valid"}, {31'b0, drv_valid}, 32'd1);
      check({tag, "_pic_no"}, {28'b0, drv_pic_no}, {28'b0, m_lfsr[3:0]});
      check({tag, "_mode"}, {31'b0, drv_mode}, {31'b0, m_lfsr[4]});
      check({tag, "_ratio"}, {30'b0, drv_ratio_mode}, {30'b0, m_lfsr[6:5]});
      last_fields = {drv_ratio_mode, drv_mode, drv_pic_no};
      m_lfsr = model_next(m_lfsr);
   endtask

   task automatic respond(input string tag, input int lat, input logic [7:0] data);
      wait_drv(tag);
      repeat (lat) @(negedge clk);
      out_valid = 1'b1;
      out_data  = data;
      m_sum     = m_sum + data;
      if (lat > m_max) m_max = lat;
      @(negedge clk);
      out_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int bound);
      for (int i = 0; i < bound; i++) begin
         if (done) break;
         @(negedge clk);
      end
      check({tag, "_done"}, {31'b0, done}, 32'd1);
   endtask

   task automatic check_final(input string tag, input int n, input logic to, input logic pr);
      check({tag, "_busy"}, {31'b0, busy}, 32'd0);
      check({tag, "_txn_cnt"}, {16'b0, txn_cnt}, n);
      check({tag, "_max_lat"}, {16'b0, max_lat}, m_max);
      check({tag, "_checksum"}, {24'b0, checksum}, {24'b0, m_sum});
      check({tag, "_err_timeout"}, {31'b0, err_timeout}, {31'b0, to});
      check({tag, "_err_protocol"}, {31'b0, err_protocol}, {31'b0, pr});
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, {31'b0, busy}, 32'd0);
      check({tag, "_done"}, {31'b0, done}, 32'd0);
      check({tag, "_drv_valid"}, {31'b0, drv_valid}, 32'd0);
      check({tag, "_drv_fields"}, {25'b0, drv_ratio_mode, drv_mode, drv_pic_no}, 32'd0);
      check({tag, "_errors"}, {30'b0, err_timeout, err_protocol}, 32'd0);
      check({tag, "_txn_cnt"}, {16'b0, txn_cnt}, 32'd0);
      check({tag, "_max_lat"}, {16'b0, max_lat}, 32'd0);
      check({tag, "_checksum"}, {24'b0, checksum}, 32'd0);
   endtask

   initial begin
      int          lat, cnt, n;
      logic [7:0]  d1, d2;
      logic [15:0] sd;
      logic [6:0]  first_fields;

      // Reset state
      #3;
      check_all_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_all_zero("post_reset");

      // Directed run: three single-beat responses at latency 4
      start_run(16'd3, 16'h0001);
      respond("dir0", 4, 8'h10);
      respond("dir1", 4, 8'h20);
      respond("dir2", 4, 8'hF0);
      wait_done("dir", 50);
      check_final("dir", 3, 1'b0, 1'b0);
      check("dir_checksum_const", {24'b0, checksum}, 32'h20);

      // Randomised run with a start pulse that must be ignored while busy
      sd = 16'($urandom);
      n  = 5;
      start_run(16'(n), sd);
      for (int t = 0; t < n; t++) begin
         respond($sformatf("rnd%0d", t), int'($urandom_range(1, 20)), 8'($urandom));
         if (t == 0) begin
            start   = 1'b1;
            num_txn = 16'd1;
            seed    = 16'h1234;
            @(negedge clk);
            start   = 1'b0;
            num_txn = 16'(n);
         end
      end
      wait_done("rnd", 50);
      check_final("rnd", n, 1'b0, 1'b0);

      // Zero-length run goes straight to done
      @(negedge clk);
      start   = 1'b1;
      num_txn = 16'd0;
      seed    = 16'h00AA;
      @(negedge clk);
      start = 1'b0;
      check("zero_done", {31'b0, done}, 32'd1);
      check("zero_busy", {31'b0, busy}, 32'd0);
      check("zero_drv_valid", {31'b0, drv_valid}, 32'd0);
      @(negedge clk);
      check("zero_busy_later", {30'b0, busy, drv_valid}, 32'd0);
      check("zero_txn_cnt", {16'b0, txn_cnt}, 32'd0);

      // Spurious response beat during the gap
      start_run(16'd2, 16'($urandom));
      respond("spur0", 3, 8'($urandom));
      out_valid = 1'b1;
      out_data  = 8'h55;
      @(negedge clk);
      out_valid = 1'b0;
      respond("spur1", 2, 8'($urandom));
      wait_done("spur", 50);
      check_final("spur", 2, 1'b0, 1'b1);

      // No response at all: timeout
      start_run(16'd1, 16'h0BAD);
      wait_drv("to");
      cnt = 0;
      for (int i = 0; i < 1100; i++) begin
         @(negedge clk);
         cnt++;
         if (err_timeout) break;
      end
      check("to_cycles_in_range", {31'b0, (cnt >= 999 && cnt <= 1000)}, 32'd1);
      check("to_done", {31'b0, done}, 32'd1);
      check_final("to", 0, 1'b1, 1'b0);

      // Four-beat engine: response cut short after two beats
      d1 = 8'($urandom);
      d2 = 8'($urandom);
      @(negedge clk);
      start4   = 1'b1;
      num_txn4 = 16'd2;
      seed4    = 16'h0007;
      @(negedge clk);
      start4 = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (drv_valid4) break;
         @(negedge clk);
      end
      check("prot_drv_valid", {31'b0, drv_valid4}, 32'd1);
      repeat (2) @(negedge clk);
      out_valid4 = 1'b1;
      out_data4  = d1;
      @(negedge clk);
      out_data4  = d2;
      @(negedge clk);
      out_valid4 = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (done4) break;
         @(negedge clk);
      end
      check("prot_done", {31'b0, done4}, 32'd1);
      check("prot_err_protocol", {31'b0, err_protocol4}, 32'd1);
      check("prot_err_timeout", {31'b0, err_timeout4}, 32'd0);
      check("prot_txn_cnt", {16'b0, txn_cnt4}, 32'd0);
      check("prot_checksum", {24'b0, checksum4}, {24'b0, 8'(d1 + d2)});

      // Asynchronous reset while waiting, then an identical replay
      sd = 16'($urandom);
      start_run(16'd3, sd);
      wait_drv("rst_first");
      first_fields = last_fields;
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      start_run(16'd3, sd);
      respond("replay0", int'($urandom_range(1, 10)), 8'($urandom));
      check("replay_first_fields", {25'b0, last_fields}, {25'b0, first_fields});
      respond("replay1", int'($urandom_range(1, 10)), 8'($urandom));
      respond("replay2", int'($urandom_range(1, 10)), 8'($urandom));
      wait_done("replay", 50);
      check_final("replay", 3, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pattern_txn_engine.md
Name: pattern_txn_engine

Overview:
- Parametrised, synthesizable stimulus/response engine for the bank-level controller testbed. It replaces the hand-written per-project PATTERN stimulus.
- Issues a programmable number of single-cycle requests with LFSR-randomised fields, then waits for each response burst.
- Measures response latency, accumulates a data checksum, and flags timeout and protocol errors.
- Sits between the testbench top and the DUT request/response ports; runs in simulation or on FPGA.

Parameters:
- PIC_W, 4, width of drv_pic_no
- RATIO_W, 2, width of drv_ratio_mode
- DATA_W, 8, width of dut_out_data and checksum
- OUT_LEN, 1, response beats expected per request (>=1)
- MAX_LAT, 1000, cycles without out_valid before timeout (>=2)
- GAP, 2, idle cycles between response end and next request (>=0)
- CNT_W, 16, width of transaction and latency counters

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a run when idle
- num_txn  in  CNT_W  requests to issue, sampled on start
- seed  in  16  LFSR seed, sampled on start
- drv_valid  out  1  request strobe to DUT (in_valid)
- drv_pic_no  out  PIC_W  request field
- drv_mode  out  1  request field
- drv_ratio_mode  out  RATIO_W  request field
- dut_out_valid  in  1  DUT response valid
- dut_out_data  in  DATA_W  DUT response data
- busy  out  1  run in progress
- done  out  1  run finished; held until next accepted start
- err_timeout  out  1  sticky per run
- err_protocol  out  1  sticky per run
- txn_cnt  out  CNT_W  responses completed
- max_lat  out  CNT_W  worst latency seen
- checksum  out  DATA_W  sum of all response beats mod 2^DATA_W

Behaviour:
- Reset: every output is 0; the LFSR is 16'h0001; FSM is IDLE. Reset mid-run aborts immediately with no done pulse.
- FSM states: IDLE, DRIVE, WAIT, RECV, GAP, DONE.
- IDLE or DONE + start:
  - Clear txn_cnt, max_lat, checksum and both error flags; clear done.
  - Load the LFSR with seed; seed 0 loads 16'h0001.
  - Go to DRIVE, or to DONE if num_txn==0.
  - done rises the cycle after start.
- start while busy is ignored.
- DRIVE (1 cycle):
  - drv_valid=1; fields taken from the current LFSR: pic_no=lfsr[PIC_W-1:0], mode=lfsr[PIC_W], ratio=lfsr[PIC_W+RATIO_W:PIC_W+1].
  - The LFSR advances at the end of the cycle (x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0).
  - Latency counter set to 1. Go to WAIT.
- Outside DRIVE, drv_valid=0 and all request fields are driven 0.
- WAIT:
  - dut_out_valid=1 at latency L: record L into max_lat if larger; add the beat to checksum; beat counter=1.
  - Then go to GAP if OUT_LEN==1, else RECV.
  - No valid: increment the latency counter. On reaching MAX_LAT, set err_timeout and go to DONE.
- RECV:
  - Each valid beat is summed into checksum.
  - dut_out_valid low before OUT_LEN beats: set err_protocol, go to DONE.
  - After OUT_LEN beats: txn_cnt+1, then go to GAP, or DONE if txn_cnt reaches num_txn.
  - txn_cnt also increments on completion in WAIT when OUT_LEN==1.
- GAP: count GAP cycles (GAP=0 passes through in 0 extra cycles, i.e. straight to DRIVE), then go to DRIVE.
- dut_out_valid=1 in IDLE, DRIVE, GAP or DONE sets err_protocol; this does not change state and the data is not summed.
- Saturation: the latency counter and max_lat saturate at all-ones; txn_cnt never exceeds num_txn.
- busy=1 in DRIVE, WAIT, RECV and GAP. done=1 only in DONE.

Decomposition:
- Shared package tb_pkg: FSM state enum, the LFSR tap constant, the default seed 16'h0001.
- One sub-module: pattern_lfsr16, holding load/seed/advance logic and exposing the state.

Test Plan:
- seed=1, num_txn=3, DUT replies 1 beat at latency 4 with 8'h10, 8'h20, 8'hF0 -> done, txn_cnt=3, max_lat=4, checksum=8'h20, no errors; drv_pic_no sequence matches the pattern_lfsr16 golden model.
- num_txn=0 -> done high one cycle after start, busy never asserts, drv_valid never asserts.
- DUT never responds, MAX_LAT=1000 -> err_timeout set 999 cycles after drv_valid, done set, txn_cnt=0.
- OUT_LEN=4, DUT drops valid after 2 beats -> err_protocol=1, done=1, txn_cnt=0.
- Spurious dut_out_valid during GAP -> err_protocol=1, run completes all num_txn, checksum excludes the spurious beat.
- rst_n pulsed low in WAIT -> all outputs 0 asynchronously; a new start with the same seed reproduces an identical drv field sequence.
